// File: rtl/data_mem_arb_pkg.sv
// Shared types and helpers for data_mem_arbiter.
// The misalignment helper is used only when DATA_MEM_ARB_MISALIGN_CHECK_EN is defined.
package data_mem_arb_pkg;

    localparam logic [2:0] DT_BYTE = 3'd0;
    localparam logic [2:0] DT_HALF = 3'd1;
    localparam logic [2:0] DT_WORD = 3'd2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_e;

    // Illegal when the size code is unknown or the address is not size-aligned.
    function automatic logic misaligned(input logic [1:0] addr_lo, input logic [2:0] dtype);
        logic bad;
        bad = 1'b0;
        if (dtype > DT_WORD)
            bad = 1'b1;
        else if (dtype == DT_HALF)
            bad = addr_lo[0];
        else if (dtype == DT_WORD)
            bad = |addr_lo;
        return bad;
    endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin grant: a lone request wins outright,
// and on a tie the port that did not win last time is chosen.
module rr_arbiter2 (
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic [1:0] o_gnt,
    output logic       o_idx
);

    always_comb begin
        o_gnt = 2'b00;
        o_idx = 1'b0;
        case (i_req)
            2'b01: begin
                o_gnt = 2'b01;
                o_idx = 1'b0;
            end
            2'b10: begin
                o_gnt = 2'b10;
                o_idx = 1'b1;
            end
            2'b11: begin
                o_idx = ~i_last;
                o_gnt = i_last ? 2'b01 : 2'b10;
            end
            default: begin
                o_gnt = 2'b00;
                o_idx = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/data_mem_arbiter.sv
// Round-robin arbiter sharing one single-ported data memory between the CPU (port 0)
// and a DMA engine (port 1). Define DATA_MEM_ARB_MISALIGN_CHECK_EN to reject misaligned accesses.
module data_mem_arbiter
    import data_mem_arb_pkg::*;
#(
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic          clock,
    input  logic          reset_n,
    input  logic [1:0]    req_valid,
    output logic [1:0]    req_ready,
    input  logic [1:0]    req_write,
    input  logic [AW-1:0] req_addr0,
    input  logic [AW-1:0] req_addr1,
    input  logic [DW-1:0] req_wdata0,
    input  logic [DW-1:0] req_wdata1,
    input  logic [2:0]    req_type0,
    input  logic [2:0]    req_type1,
    output logic [1:0]    resp_valid,
    output logic [DW-1:0] resp_rdata,
    output logic          resp_err,
    output logic [AW-1:0] mem_address,
    output logic [DW-1:0] mem_write_data,
    output logic          mem_MemWrite,
    output logic [2:0]    mem_data_type,
    input  logic [DW-1:0] mem_ReadData
);

    arb_state_e    r_state;
    logic          r_last;
    logic          r_gidx;
    logic          r_err;
    logic [AW-1:0] r_mem_addr;
    logic [DW-1:0] r_mem_wdata;
    logic          r_mem_we;
    logic [2:0]    r_mem_type;
    logic [1:0]    r_resp_valid;
    logic [DW-1:0] r_resp_rdata;
    logic          r_resp_err;

    logic [1:0]    w_gnt;
    logic          w_idx;
    logic [AW-1:0] w_sel_addr;
    logic [DW-1:0] w_sel_wdata;
    logic [2:0]    w_sel_type;
    logic          w_sel_write;
    logic          w_err;

    rr_arbiter2 u_rr (
        .i_req  (req_valid),
        .i_last (r_last),
        .o_gnt  (w_gnt),
        .o_idx  (w_idx)
    );

    assign w_sel_addr  = w_idx ? req_addr1  : req_addr0;
    assign w_sel_wdata = w_idx ? req_wdata1 : req_wdata0;
    assign w_sel_type  = w_idx ? req_type1  : req_type0;
    assign w_sel_write = req_write[w_idx];

`ifdef DATA_MEM_ARB_MISALIGN_CHECK_EN
    assign w_err = misaligned(w_sel_addr[1:0], w_sel_type);
`else
    assign w_err = 1'b0;
`endif

    // Accept only from IDLE; the requester sees ready in the same cycle it is granted.
    assign req_ready = (r_state == IDLE) ? w_gnt : 2'b00;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_last       <= 1'b1;
            r_gidx       <= 1'b0;
            r_err        <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_we     <= 1'b0;
            r_mem_type   <= 3'd0;
            r_resp_valid <= 2'b00;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (|req_valid) begin
                        r_state     <= ACCESS;
                        r_gidx      <= w_idx;
                        r_last      <= w_idx;
                        r_err       <= w_err;
                        r_mem_addr  <= w_sel_addr;
                        r_mem_wdata <= w_sel_wdata;
                        r_mem_type  <= w_sel_type;
                        r_mem_we    <= w_sel_write & ~w_err;
                    end
                end
                ACCESS: begin
                    // Stores and rejected accesses return zero data.
                    r_resp_rdata <= (r_err | r_mem_we) ? '0 : mem_ReadData;
                    r_resp_err   <= r_err;
                    r_resp_valid <= r_gidx ? 2'b10 : 2'b01;
                    r_mem_we     <= 1'b0;
                    r_state      <= RESP;
                end
                RESP: begin
                    r_resp_valid <= 2'b00;
                    r_state      <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign resp_valid     = r_resp_valid;
    assign resp_rdata     = r_resp_rdata;
    assign resp_err       = r_resp_err;
    assign mem_address    = r_mem_addr;
    assign mem_write_data = r_mem_wdata;
    assign mem_MemWrite   = r_mem_we;
    assign mem_data_type  = r_mem_type;

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Randomised bench for data_mem_arbiter against a transaction-level model with a byte memory.
// Honours DATA_MEM_ARB_MISALIGN_CHECK_EN the same way as the design.
module tb_data_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic [1:0]  req_valid = 2'b00;
    logic [1:0]  req_ready;
    logic [1:0]  req_write = 2'b00;
    logic [31:0] req_addr0 = '0, req_addr1 = '0;
    logic [31:0] req_wdata0 = '0, req_wdata1 = '0;
    logic [2:0]  req_type0 = '0, req_type1 = '0;
    logic [1:0]  resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] mem_address;
    logic [31:0] mem_write_data;
    logic        mem_MemWrite;
    logic [2:0]  mem_data_type;
    logic [31:0] mem_ReadData;
    logic        mem_init = 1'b1;

    always #5 clock = ~clock;

    data_mem_arbiter #(.AW(32), .DW(32)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr0(req_addr0), .req_addr1(req_addr1),
        .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
        .req_type0(req_type0), .req_type1(req_type1),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .mem_address(mem_address), .mem_write_data(mem_write_data),
        .mem_MemWrite(mem_MemWrite), .mem_data_type(mem_data_type),
        .mem_ReadData(mem_ReadData)
    );

    function automatic int nb(input logic [2:0] t);
        return (t == 3'd0) ? 1 : (t == 3'd1) ? 2 : 4;
    endfunction

    function automatic logic [7:0] pat(input int i);
        return 8'(i * 37 + 11);
    endfunction

    // Environment memory standing in for data_memory: little-endian bytes, zero-extended reads.
    logic [7:0] env_mem [256];
    always_comb begin
        mem_ReadData = '0;
        for (int i = 0; i < 4; i++)
            if (i < nb(mem_data_type))
                mem_ReadData[8*i +: 8] = env_mem[8'(mem_address + 32'(i))];
    end
    always @(posedge clock) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) env_mem[i] <= pat(i);
        end else if (mem_MemWrite) begin
            for (int i = 0; i < 4; i++)
                if (i < nb(mem_data_type))
                    env_mem[8'(mem_address + 32'(i))] <= mem_write_data[8*i +: 8];
        end
    end

    // ---------------- reference model ----------------
    typedef struct {
        logic        v;
        logic        w;
        logic [31:0] a;
        logic [31:0] d;
        logic [2:0]  t;
    } req_t;

    req_t        rq [2];
    logic [7:0]  ref_mem [256];
    int          ph;          // 0 idle, 1 access cycle, 2 response cycle
    logic        last_g;
    logic [1:0]  x_vld;
    logic        x_we, x_err;
    logic [31:0] x_addr, x_wdata, x_rdata;
    logic [2:0]  x_type;
    int          n_vec = 0;
    int          n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_read(input logic [31:0] a, input logic [2:0] t);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < nb(t); i++) r[8*i +: 8] = ref_mem[8'(a + 32'(i))];
        return r;
    endfunction

    function automatic logic ref_err(input logic [31:0] a, input logic [2:0] t);
`ifdef DATA_MEM_ARB_MISALIGN_CHECK_EN
        return (t > 3'd2) || (t == 3'd1 && (a % 2) != 0) || (t == 3'd2 && (a % 4) != 0);
`else
        return 1'b0;
`endif
    endfunction

    task automatic drive();
        req_valid  = {rq[1].v, rq[0].v};
        req_write  = {rq[1].w, rq[0].w};
        req_addr0  = rq[0].a;  req_addr1  = rq[1].a;
        req_wdata0 = rq[0].d;  req_wdata1 = rq[1].d;
        req_type0  = rq[0].t;  req_type1  = rq[1].t;
    endtask

    task automatic set_req(input int p, input logic w, input logic [31:0] a,
                           input logic [31:0] d, input logic [2:0] t);
        rq[p].v = 1'b1; rq[p].w = w; rq[p].a = a; rq[p].d = d; rq[p].t = t;
    endtask

    // One clock cycle: drive at negedge, check, advance the model at posedge.
    task automatic tick();
        int g;
        logic [1:0] eg;
        logic e;
        drive();
        #1;
        g = -1;
        if (ph == 0) begin
            if (rq[0].v && rq[1].v) g = last_g ? 0 : 1;
            else if (rq[0].v)       g = 0;
            else if (rq[1].v)       g = 1;
        end
        eg = (g == 0) ? 2'b01 : (g == 1) ? 2'b10 : 2'b00;
        chk("req_ready", req_ready, eg);
        chk("resp_valid", resp_valid, (ph == 2) ? x_vld : 2'b00);
        chk("mem_MemWrite", mem_MemWrite, (ph == 1) ? x_we : 1'b0);
        if (ph == 1) begin
            chk("mem_address", mem_address, x_addr);
            chk("mem_write_data", mem_write_data, x_wdata);
            chk("mem_data_type", mem_data_type, x_type);
        end
        if (ph == 2) begin
            chk("resp_rdata", resp_rdata, x_rdata);
            chk("resp_err", resp_err, x_err);
        end
        @(posedge clock);
        if (ph == 0 && g >= 0) begin
            e       = ref_err(rq[g].a, rq[g].t);
            x_vld   = eg;
            x_we    = rq[g].w & ~e;
            x_err   = e;
            x_addr  = rq[g].a;
            x_wdata = rq[g].d;
            x_type  = rq[g].t;
            x_rdata = (rq[g].w || e) ? 32'h0 : ref_read(rq[g].a, rq[g].t);
            last_g  = (g == 1);
            rq[g].v = 1'b0;
            ph      = 1;
        end else if (ph == 1) begin
            if (x_we)
                for (int i = 0; i < nb(x_type); i++) ref_mem[8'(x_addr + 32'(i))] = x_wdata[8*i +: 8];
            ph = 2;
        end else if (ph == 2) begin
            ph = 0;
        end
        @(negedge clock);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((ph != 0 || rq[0].v || rq[1].v) && n < 60) begin
            tick();
            n++;
        end
        chk("drain_bound", (n < 60), 1'b1);
    endtask

    task automatic model_reset();
        ph = 0; last_g = 1'b1; rq[0].v = 1'b0; rq[1].v = 1'b0;
    endtask

    initial begin
        logic [2:0] t;
        logic [31:0] a;
        for (int i = 0; i < 256; i++) ref_mem[i] = pat(i);
        for (int p = 0; p < 2; p++) begin
            rq[p].v = 1'b0; rq[p].w = 1'b0; rq[p].a = '0; rq[p].d = '0; rq[p].t = '0;
        end
        model_reset();
        x_vld = '0; x_we = 0; x_err = 0; x_addr = '0; x_wdata = '0; x_rdata = '0; x_type = '0;
        drive();
        repeat (2) @(negedge clock);
        mem_init = 1'b0;

        // Reset state
        chk("rst_req_ready", req_ready, 2'b00);
        chk("rst_resp_valid", resp_valid, 2'b00);
        chk("rst_resp_rdata", resp_rdata, 32'h0);
        chk("rst_resp_err", resp_err, 1'b0);
        chk("rst_mem_address", mem_address, 32'h0);
        chk("rst_mem_write_data", mem_write_data, 32'h0);
        chk("rst_mem_MemWrite", mem_MemWrite, 1'b0);
        chk("rst_mem_data_type", mem_data_type, 3'd0);
        reset_n = 1'b1;
        @(negedge clock);

        // Port 0 store then load of the same word
        set_req(0, 1'b1, 32'h8, 32'hFFFF_FFF8, 3'd2);
        drain();
        set_req(0, 1'b0, 32'h8, 32'h0, 3'd2);
        drain();

        // Port 1 half store at an odd address, then word readback
        set_req(1, 1'b1, 32'hB, 32'h0000_BEEF, 3'd1);
        drain();
        set_req(1, 1'b0, 32'h8, 32'h0, 3'd2);
        drain();

        // Port 1 withdraws while port 0 is busy; next tie must go to port 1
        set_req(0, 1'b0, 32'h20, 32'h0, 3'd2);
        tick();
        set_req(1, 1'b1, 32'h24, 32'hDEAD_0001, 3'd2);
        tick();
        rq[1].v = 1'b0;
        tick();
        tick();
        set_req(0, 1'b0, 32'h28, 32'h0, 3'd2);
        set_req(1, 1'b0, 32'h2C, 32'h0, 3'd2);
        drain();

        // Continuous contention: both ports keep loads pending
        for (int k = 0; k < 14; k++) begin
            for (int p = 0; p < 2; p++)
                if (!rq[p].v) set_req(p, 1'b0, 32'(4 * $urandom_range(0, 15)), 32'h0, 3'd2);
            tick();
        end
        drain();

        // Reset during ACCESS of a store: store must not land, no response
        set_req(0, 1'b1, 32'h10, 32'h1234_5678, 3'd2);
        tick();
        chk("pre_rst_we", mem_MemWrite, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("rst_acc_we", mem_MemWrite, 1'b0);
        chk("rst_acc_resp_valid", resp_valid, 2'b00);
        @(posedge clock);
        #1;
        chk("rst_hold_resp_valid", resp_valid, 2'b00);
        @(negedge clock);
        reset_n = 1'b1;
        model_reset();
        chk("post_rst_rdata", resp_rdata, 32'h0);
        // First tie after reset goes to port 0; then read 0x10 back
        set_req(0, 1'b0, 32'h10, 32'h0, 3'd2);
        set_req(1, 1'b0, 32'h10, 32'h0, 3'd2);
        drain();

        // Randomised traffic
        for (int k = 0; k < 400; k++) begin
            for (int p = 0; p < 2; p++) begin
                if (!rq[p].v && $urandom_range(0, 2) == 0) begin
`ifdef DATA_MEM_ARB_MISALIGN_CHECK_EN
                    t = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
                    a = 32'($urandom_range(0, 63));
`else
                    t = 3'($urandom_range(0, 2));
                    a = 32'($urandom_range(0, 63));
                    a = (t == 3'd2) ? (a & ~32'h3) : (t == 3'd1) ? (a & ~32'h1) : a;
`endif
                    set_req(p, 1'($urandom_range(0, 1)), a, $urandom, t);
                end else if (rq[p].v && ph != 0 && $urandom_range(0, 15) == 0) begin
                    rq[p].v = 1'b0;
                end
            end
            tick();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/data_mem_arbiter.md
# data_mem_arbiter

Two-requester arbiter that shares the single-ported `data_memory` between the CPU load/store port (port 0) and a DMA engine (port 1). Each port uses a valid/ready handshake. The block grants one access at a time with round-robin fairness, drives the memory's address/write_data/MemWrite/data_type inputs from registers, and returns the read data to the granted port as a one-cycle response pulse.

## Interface
- `AW`, default 32: address width.
- `DW`, default 32: data width.
- `clock` in 1: single clock; all state updates on rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid[1:0]` in 2: per-port request valid.
- `req_ready[1:0]` out 2: per-port request accepted this cycle.
- `req_write[1:0]` in 2: 1 = store, 0 = load.
- `req_addr0`, `req_addr1` in AW: byte address.
- `req_wdata0`, `req_wdata1` in DW: store data.
- `req_type0`, `req_type1` in 3: access size (DT_BYTE / DT_HALF / DT_WORD).
- `resp_valid[1:0]` out 2: one-cycle response pulse for the port.
- `resp_rdata` out DW: load data, valid with `resp_valid`.
- `resp_err` out 1: misaligned/illegal access flag, valid with `resp_valid`.
- `mem_address` out AW: to data_memory address.
- `mem_write_data` out DW: to data_memory write_data.
- `mem_MemWrite` out 1: to data_memory MemWrite.
- `mem_data_type` out 3: to data_memory data_type.
- `mem_ReadData` in DW: from data_memory; combinational read.

## Operation
- FSM states: IDLE, ACCESS, RESP. Reset state is IDLE.
- **IDLE:**
  - If any `req_valid` is high, grant exactly one port and assert its `req_ready` combinationally.
  - At the clock edge, go to ACCESS.
  - Latch into the `mem_*` registers: address, wdata, type, and `mem_MemWrite = req_write & ~err`.
  - Latch the granted port index and `err`.
- **Arbitration:**
  - A single valid request wins outright.
  - If both are valid, the port that is not `last_grant` wins.
  - `last_grant` updates to the granted port on accept.
- **ACCESS (one cycle):**
  - The memory sees stable inputs. A store commits at the edge that ends ACCESS.
  - `mem_ReadData` is captured into `resp_rdata` at the same edge. It is forced to 0 if `err` is set or the access is a store.
  - `mem_MemWrite` clears at that edge. Go to RESP.
- **RESP (one cycle):**
  - `resp_valid[grant] = 1`; `resp_err` equals the latched `err`.
  - Go to IDLE. `req_ready` stays 0 in ACCESS and RESP.
- Requesters must hold `req_*` stable while `req_valid` is high and `req_ready` is low. A requester may drop `req_valid` before it is granted without side effects.
- `mem_data_type` is passed through unchanged. Byte lane handling belongs to data_memory.

## Timing
- Reset values:
  - `req_ready` = 0.
  - `resp_valid` = 0.
  - `resp_rdata` = 0.
  - `resp_err` = 0.
  - All `mem_*` outputs = 0.
  - `last_grant` = 1, so port 0 wins the first tie.
- Latency: accept at edge T; store commits at T+1; `resp_valid` is high in the cycle after edge T+1 and falls at T+2.
- Throughput: one access per 3 cycles; 50/50 alternation under continuous contention.
- Reset asserted mid-ACCESS: `mem_MemWrite` drops asynchronously, so the store is not committed and no response is issued. After reset, the FSM is in IDLE.
- Reset mid-RESP: the response is lost and `resp_valid` drops immediately.
- Simultaneous events:
  - A new `req_valid` arriving during ACCESS or RESP waits for IDLE.
  - A port whose response is in RESP may already hold its next `req_valid`. It is arbitrated in the next IDLE.

## Configuration
- Macro: `DATA_MEM_ARB_MISALIGN_CHECK_EN`.
- **Defined:** `err` = 1 in either case below:
  - DT_HALF with `addr[0]` = 1, or DT_WORD with `addr[1:0]` ≠ 0.
  - Type code > DT_WORD.
  
  An erroring access still spends ACCESS and RESP cycles, with `mem_MemWrite` = 0, `resp_rdata` = 0 and `resp_err` = 1.
- **Undefined:** `err` is constant 0, every access goes to memory unmodified, and `resp_err` is tied 0.

## Structure
- Package `data_mem_arb_pkg`:
  - DT_BYTE = 3'd0, DT_HALF = 3'd1, DT_WORD = 3'd2.
  - State encoding: IDLE = 2'd0, ACCESS = 2'd1, RESP = 2'd2.
  - Misalignment check function.
- Sub-module `rr_arbiter2`: combinational 2-way round-robin grant from `req_valid` and `last_grant`, returning one-hot grant and index. `last_grant` register stays in the top module.

## Test plan
1. **Reset:** `reset_n` = 0 → all outputs 0, FSM IDLE.
2. **Port 0 store then load:**
   - Stimulus: port 0 stores word 32'hFFFF_FFF8 at 32'h8; later, port 0 loads DT_WORD at 32'h8.
   - Required:
     - `req_ready[0]` pulses.
     - `mem_MemWrite` = 1 for exactly one cycle.
     - `resp_valid[0]` is high in the cycle after edge T+1.
     - `resp_rdata` = 32'hFFFF_FFF8.
3. **Contention:**
   - Stimulus: both ports hold loads continuously.
   - Required:
     - Grants follow 0, 1, 0, 1.
     - Accepts are 3 cycles apart.
     - Each `resp_valid` goes to the matching port only.
4. **Misaligned access, macro defined:**
   - Stimulus: port 1 issues a DT_HALF store to 32'hA... wait, use 32'hB.
   - Required: `mem_MemWrite` stays 0, `resp_err` = 1, `resp_rdata` = 0, and the memory word is unchanged on a later readback.
   
   With the macro undefined, the same stimulus → store performed and `resp_err` = 0.
5. **Reset during ACCESS of a store:**
   - Stimulus: store 32'h1234_5678 to 32'h10, then assert reset during ACCESS.
   - Required: no `resp_valid`; a readback of 32'h10 returns the prior value.
6. **Early withdrawal:** port 1 drops `req_valid` before grant while port 0 is busy → no port-1 access occurs and `last_grant` is unaffected.
